// File: rtl/centroid_smoother.sv
`default_nettype none
// ============================================================================
// Module   : centroid_smoother
// Brief    : Moving-average smoother for per-frame camera centroids. It drops
//            the target after a run of lost frames and maps the result into
//            display space. Define CENTROID_SCALE_EN to enable display
//            scaling, mirroring and clamping.
// Revision : 1.0
// ============================================================================
module centroid_smoother #(
  parameter int IN_W       = 9,
  parameter int OUT_W      = 12,
  parameter int LOG_DEPTH  = 3,
  parameter int SRC_W      = 320,
  parameter int SRC_H      = 240,
  parameter int DST_W      = 1280,
  parameter int DST_H      = 1024,
  parameter int MIRROR_X   = 1,
  parameter int LOST_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_present,
  input  logic [IN_W-1:0]      in_x,
  input  logic [IN_W-1:0]      in_y,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_x,
  output logic [OUT_W-1:0]     out_y,
  output logic                 out_locked,
  output logic [LOG_DEPTH:0]   fill
);

  localparam int                DEPTH     = 1 << LOG_DEPTH;
  localparam int                SUM_W     = IN_W + LOG_DEPTH;
  localparam int                FILL_W    = LOG_DEPTH + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [IN_W-1:0]   X_MAX     = IN_W'(SRC_W - 1);
  localparam logic [IN_W-1:0]   Y_MAX     = IN_W'(SRC_H - 1);
  localparam logic [7:0]        LOST_MAX  = 8'(LOST_LIMIT);

  if (LOG_DEPTH < 1 || LOG_DEPTH > 6 || LOST_LIMIT < 1 || LOST_LIMIT > 255 ||
      SRC_W < 1 || SRC_H < 1 || DST_W < 1 || DST_H < 1 ||
      MIRROR_X < 0 || MIRROR_X > 1 || OUT_W < IN_W) begin : g_param_check
    $error("centroid_smoother: parameter out of range");
  end

  logic [IN_W-1:0]      win_x [DEPTH];
  logic [IN_W-1:0]      win_y [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [SUM_W-1:0]     sum_x, sum_y;
  logic [IN_W-1:0]      newest_x, newest_y;
  logic [7:0]           lost_cnt;
  logic                 s1_valid;

  logic                 accept, lost_rpt, drop, clear, full;
  logic [IN_W-1:0]      clamp_x, clamp_y, evict_x, evict_y, avg_x, avg_y;
  logic [OUT_W-1:0]     next_x, next_y;

  assign full     = (fill == FILL_FULL);
  assign accept   = in_valid & in_present & ~flush;
  assign lost_rpt = in_valid & ~in_present & ~flush;
  assign drop     = lost_rpt && (lost_cnt >= LOST_MAX - 8'd1);
  assign clear    = flush | drop;

  assign clamp_x  = (in_x > X_MAX) ? X_MAX : in_x;
  assign clamp_y  = (in_y > Y_MAX) ? Y_MAX : in_y;
  // The slot being overwritten only holds a live sample once the window is full
  assign evict_x  = full ? win_x[wr_ptr] : '0;
  assign evict_y  = full ? win_y[wr_ptr] : '0;

  // sum/fill/newest act as the stage-1 registers for the sample accepted last cycle
  assign avg_x    = full ? IN_W'(sum_x >> LOG_DEPTH) : newest_x;
  assign avg_y    = full ? IN_W'(sum_y >> LOG_DEPTH) : newest_y;

`ifdef CENTROID_SCALE_EN
  localparam int SX = DST_W / SRC_W;
  localparam int SY = DST_H / SRC_H;
  int sc_x, sc_y;

  always_comb begin
    sc_x = int'(avg_x) * SX;
    if (MIRROR_X != 0) sc_x = (DST_W - 1) - sc_x;
    if (sc_x > DST_W - 1) sc_x = DST_W - 1;
    if (sc_x < 0) sc_x = 0;
    sc_y = int'(avg_y) * SY;
    if (sc_y > DST_H - 1) sc_y = DST_H - 1;
    next_x = OUT_W'(sc_x);
    next_y = OUT_W'(sc_y);
  end
`else
  assign next_x = OUT_W'(avg_x);
  assign next_y = OUT_W'(avg_y);
`endif

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      win_x[wr_ptr] <= clamp_x;
      win_y[wr_ptr] <= clamp_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      fill       <= '0;
      newest_x   <= '0;
      newest_y   <= '0;
      lost_cnt   <= '0;
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_locked <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (clear) begin
        wr_ptr   <= '0;
        sum_x    <= '0;
        sum_y    <= '0;
        fill     <= '0;
        lost_cnt <= flush ? 8'd0 : LOST_MAX;
      end else if (accept) begin
        wr_ptr   <= wr_ptr + LOG_DEPTH'(1);
        sum_x    <= sum_x + SUM_W'(clamp_x) - SUM_W'(evict_x);
        sum_y    <= sum_y + SUM_W'(clamp_y) - SUM_W'(evict_y);
        fill     <= full ? fill : fill + FILL_W'(1);
        newest_x <= clamp_x;
        newest_y <= clamp_y;
        lost_cnt <= '0;
      end else if (lost_rpt) begin
        lost_cnt <= lost_cnt + 8'd1;
      end

      // An in-flight result still issues across a clear, but never as locked
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_x <= next_x;
        out_y <= next_y;
      end
      if (clear) out_locked <= 1'b0;
      else if (s1_valid && full) out_locked <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_centroid_smoother.sv
`default_nettype none
// tb_centroid_smoother: scoreboard bench for centroid_smoother; expected results
// are queued when a sample is driven and compared when out_valid fires.
module tb_centroid_smoother;
  localparam int IN_W = 9, OUT_W = 12, LOG_DEPTH = 3, DEPTH = 8;
  localparam int SRC_W = 320, SRC_H = 240, DST_W = 1280, DST_H = 1024;
  localparam int MIRROR_X = 1, LOST_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset, in_valid, in_present, flush;
  logic [IN_W-1:0]   in_x, in_y;
  logic              out_valid, out_locked;
  logic [OUT_W-1:0]  out_x, out_y;
  logic [LOG_DEPTH:0] fill;

  centroid_smoother #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LOG_DEPTH(LOG_DEPTH), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .DST_W(DST_W), .DST_H(DST_H), .MIRROR_X(MIRROR_X), .LOST_LIMIT(LOST_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_present(in_present),
    .in_x(in_x), .in_y(in_y), .flush(flush), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .out_locked(out_locked), .fill(fill)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model
  typedef struct { int due; int x; int y; int locked; } exp_t;
  exp_t sbq[$];
  int m_win_x[DEPTH], m_win_y[DEPTH];
  int m_sum_x, m_sum_y, m_fill, m_wp, m_lost;

  function automatic int disp_x(input int a);
`ifdef CENTROID_SCALE_EN
    int v;
    v = a * (DST_W / SRC_W);
    if (MIRROR_X != 0) v = (DST_W - 1) - v;
    if (v > DST_W - 1) v = DST_W - 1;
    if (v < 0) v = 0;
    return v;
`else
    return a;
`endif
  endfunction

  function automatic int disp_y(input int a);
`ifdef CENTROID_SCALE_EN
    int v;
    v = a * (DST_H / SRC_H);
    if (v > DST_H - 1) v = DST_H - 1;
    return v;
`else
    return a;
`endif
  endfunction

  task automatic model_clear();
    m_sum_x = 0; m_sum_y = 0; m_fill = 0; m_wp = 0;
    foreach (sbq[i]) if (sbq[i].due > cyc) sbq[i].locked = 0;
  endtask

  task automatic step(input bit v, input bit p, input int x, input int y, input bit f);
    int cx, cy, ax, ay;
    in_valid = v; in_present = p; flush = f;
    in_x = IN_W'(x); in_y = IN_W'(y);
    if (f) begin
      model_clear();
      m_lost = 0;
    end else if (v && p) begin
      cx = (x > SRC_W - 1) ? SRC_W - 1 : x;
      cy = (y > SRC_H - 1) ? SRC_H - 1 : y;
      if (m_fill == DEPTH) begin
        m_sum_x -= m_win_x[m_wp];
        m_sum_y -= m_win_y[m_wp];
      end
      m_sum_x += cx; m_sum_y += cy;
      m_win_x[m_wp] = cx; m_win_y[m_wp] = cy;
      m_wp = (m_wp + 1) % DEPTH;
      if (m_fill < DEPTH) m_fill++;
      m_lost = 0;
      ax = (m_fill == DEPTH) ? m_sum_x / DEPTH : cx;
      ay = (m_fill == DEPTH) ? m_sum_y / DEPTH : cy;
      sbq.push_back('{cyc + 2, disp_x(ax), disp_y(ay), (m_fill == DEPTH) ? 1 : 0});
    end else if (v) begin
      if (m_lost < LOST_LIMIT) m_lost++;
      if (m_lost == LOST_LIMIT) model_clear();
    end
    @(posedge clk);
    @(negedge clk);
    check("fill", fill, m_fill);
    in_valid = 0; in_present = 0; flush = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; in_present = 0; flush = 0;
    sbq.delete();
    m_sum_x = 0; m_sum_y = 0; m_fill = 0; m_wp = 0; m_lost = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  exp_t e;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      check("missing_valid", 0, 1);
      void'(sbq.pop_front());
    end
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) check("spurious_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        check("valid_cycle", cyc, e.due);
        check("out_x", out_x, e.x);
        check("out_y", out_y, e.y);
        check("out_locked", out_locked, e.locked);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; in_valid = 0; in_present = 0; flush = 0; in_x = '0; in_y = '0;
    m_sum_x = 0; m_sum_y = 0; m_fill = 0; m_wp = 0; m_lost = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_locked", out_locked, 0);
    check("rst_fill", fill, 0);
    reset = 0;

    // Window fill, back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 1, 100, 50, 0);
      check("fill_count", fill, i + 1);
    end
    idle(3);
`ifdef CENTROID_SCALE_EN
    check("fill_x_lit", out_x, 879);
    check("fill_y_lit", out_y, 200);
`else
    check("fill_x_lit", out_x, 100);
    check("fill_y_lit", out_y, 50);
`endif
    check("fill_locked", out_locked, 1);

    // Running average
    step(1, 1, 180, 50, 0);
    idle(3);
`ifdef CENTROID_SCALE_EN
    check("avg_x_lit", out_x, 839);
`else
    check("avg_x_lit", out_x, 110);
`endif

    // Lost drop
    for (int i = 0; i < LOST_LIMIT - 1; i++) begin
      step(1, 0, 0, 0, 0);
      check("lost_locked_hold", out_locked, 1);
    end
    step(1, 0, 0, 0, 0);
    check("drop_fill", fill, 0);
    check("drop_locked", out_locked, 0);
    step(1, 1, 20, 20, 0);
    idle(3);
`ifdef CENTROID_SCALE_EN
    check("reacq_x_lit", out_x, 1199);
`else
    check("reacq_x_lit", out_x, 20);
`endif
    check("reacq_locked", out_locked, 0);

    // Clamp on an empty window
    step(0, 0, 0, 0, 1);
    idle(2);
    step(1, 1, 400, 300, 0);
    idle(3);
`ifdef CENTROID_SCALE_EN
    check("clamp_x_lit", out_x, 3);
    check("clamp_y_lit", out_y, 956);
`else
    check("clamp_x_lit", out_x, 319);
    check("clamp_y_lit", out_y, 239);
`endif

    // Flush wins over a simultaneous sample
    step(1, 1, 50, 50, 1);
    check("flush_fill", fill, 0);
    idle(3);

    // Flush right behind an accept on a full window: result issues unlocked
    for (int i = 0; i < DEPTH; i++) step(1, 1, 10 + i, 20 + i, 0);
    step(1, 1, 300, 200, 0);
    step(0, 0, 0, 0, 1);
    idle(3);

    // Randomised mix with wrap-around
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 15) step(1, 1, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 0);
      else if (r < 19) step(1, 0, 0, 0, 0);
      else step(0, 0, 0, 0, 1);
    end
    idle(4);

    // Reset one cycle after an accept kills the in-flight result
    step(1, 1, 100, 50, 0);
    do_reset();
    check("rstmid_valid", out_valid, 0);
    check("rstmid_x", out_x, 0);
    check("rstmid_y", out_y, 0);
    check("rstmid_locked", out_locked, 0);
    check("rstmid_fill", fill, 0);
    idle(3);

    check("queue_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/centroid_smoother.md
# centroid_smoother

Parametrised successor to the fixed camera-to-display coordinate path. It sits between the frame-capture centroid output (one target X/Y per frame, camera space) and the display/game logic. Each accepted sample goes into a circular window of 2^LOG_DEPTH entries. The block keeps a running-sum moving average, drops the target after a run of lost frames, and scales and mirrors the result into display coordinates with clamping.

## Interface
Parameters:
- IN_W, 9, camera coordinate width
- OUT_W, 12, display coordinate width
- LOG_DEPTH, 3, log2 of window depth (DEPTH = 2^LOG_DEPTH, 1..6)
- SRC_W / SRC_H, 320 / 240, camera resolution
- DST_W / DST_H, 1280 / 1024, display resolution
- MIRROR_X, 1, 1 = horizontally mirror X
- LOST_LIMIT, 4, consecutive not-present samples before the target is dropped (1..255)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  one-cycle strobe; a new centroid report
- in_present  in  1  target detected in this report; qualifies in_x/in_y
- in_x, in_y  in  IN_W  camera-space centroid
- flush  in  1  synchronous window clear
- out_valid  out  1  one-cycle strobe; out_x/out_y updated
- out_x, out_y  out  OUT_W  display-space smoothed position
- out_locked  out  1  window full, average is live
- fill  out  LOG_DEPTH+1  valid entries in window, 0..DEPTH

## Operation
- Accept: in_valid & in_present & ~flush.
  - Clamp in_x to SRC_W-1 and in_y to SRC_H-1.
  - Write the sample at wr_ptr, then advance wr_ptr modulo DEPTH.
  - Update sum (width IN_W+LOG_DEPTH, never overflows): sum = sum + new - evicted. The evicted value is 0 while fill < DEPTH.
  - fill saturates at DEPTH.
  - Lost counter clears.
- Lost report: in_valid & ~in_present & ~flush.
  - The lost counter increments, saturating at LOST_LIMIT.
  - On reaching LOST_LIMIT, clear window, sum, fill and wr_ptr, and set out_locked=0.
  - out_x/out_y hold. No out_valid.
- Average:
  - fill == DEPTH: avg = sum >> LOG_DEPTH (truncating).
  - Otherwise: avg = newest sample, unaveraged.
- Scale: SX = DST_W/SRC_W and SY = DST_H/SRC_H, both integer division at elaboration.
  - out_x = MIRROR_X ? (DST_W-1) - avg_x*SX : avg_x*SX
  - out_y = avg_y*SY
  - Clamp both to DST-1.
- out_locked is set on the out_valid where fill reaches DEPTH. It is cleared by lost-drop, flush or reset.
- flush: same clearing as lost-drop, plus clears the lost counter. out_x/out_y hold.
  - flush & in_valid in the same cycle: flush wins and the sample is discarded.
- Reset: out_valid=0, out_x=0, out_y=0, out_locked=0, fill=0, sum=0, wr_ptr=0, lost counter=0. Window contents are don't-care.

## Timing
- Two-stage pipeline:
  - Cycle N: accept.
  - Cycle N+1: sum, fill and newest sample registered.
  - Cycle N+2: out_valid=1 for exactly one cycle, with out_x/out_y/out_locked valid.
- fill reflects an accept at N+1.
- Back-to-back accepts every cycle are supported, giving an out_valid every cycle after 2 cycles of latency.
- Lost-drop or flush at cycle N:
  - fill=0 and out_locked=0 at N+1.
  - An out_valid already in flight from N-1 still issues at N+1 with its pre-clear values, except out_locked, which reads 0.
- Reset mid-pipeline kills in-flight out_valid.
- Wrap-around: eviction of slot wr_ptr happens in the same cycle it is overwritten.

## Configuration
- CENTROID_SCALE_EN
  - Defined: scaling, mirroring and display clamping as above.
  - Undefined: out_x/out_y = zero-extended clamped camera-space avg. DST_* and MIRROR_X are ignored. Pipeline latency is unchanged (still 2 cycles).

## Test plan
Defaults, CENTROID_SCALE_EN defined unless stated.
- Window fill: 8 accepts of x=100, y=50 → eight out_valid pulses at N+2, each with out_x=879 and out_y=200. out_locked=0 on the first 7 and 1 on the 8th. fill counts 1..8.
- Running average: after the fill case, one accept of x=180, y=50 → sum_x=880, avg 110 → out_x=839, out_y=200, out_locked=1.
- Lost drop: 3 not-present reports → out_locked stays 1 and there is no out_valid. A 4th → fill=0 and out_locked=0. Next accept of x=20 → out_x=1199, out_locked=0.
- Clamp/boundary:
  - in_x=400, in_y=300 on an empty window → out_x=3, out_y=956.
  - flush asserted with in_valid in the same cycle → no out_valid at N+2, fill=0.
- Macro off: accept of x=100, y=50 → out_x=100, out_y=50 at N+2.
- Reset mid-operation: assert reset at N+1 after an accept → no out_valid at N+2. All outputs 0, fill=0.
